// File: rtl/tdc_therm_decoder_pkg.sv
// Shared TDC definitions: decoder FSM states, default code width and the
// derivation of the signed phase-error width from the thermometer width.
package tdc_pkg;

    localparam int TDC_CODE_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Sign bit plus enough magnitude bits to hold +/-code_w.
    function automatic int err_w_for(input int code_w);
        return $clog2(code_w) + 2;
    endfunction

endpackage

// File: rtl/tdc_therm_decoder_if.sv
// Bundle between the TDC thermometer outputs and the phase-error decoder.
interface tdc_therm_decoder_if
    import tdc_pkg::*;
#(
    parameter int CODE_W = TDC_CODE_W,
    parameter int ERR_W  = err_w_for(CODE_W)
);
    logic [CODE_W-1:0]       up_error;
    logic [CODE_W-1:0]       dwn_error;
    // There is no back-pressure: err_valid is a one-cycle strobe, and
    // phase_err/sat/timeout are meaningful only while it is high (they hold otherwise).
    logic signed [ERR_W-1:0] phase_err;
    logic                    err_valid;
    logic                    sat;
    logic                    timeout;
    logic                    lock;

    modport master (
        output up_error, dwn_error,
        input  phase_err, err_valid, sat, timeout, lock
    );

    modport slave (
        input  up_error, dwn_error,
        output phase_err, err_valid, sat, timeout, lock
    );
endinterface

// File: rtl/tdc_therm_decoder_popcount.sv
// Combinational ones-counter; counting ones rather than finding the top
// set bit makes the decoder tolerant of thermometer bubbles.
module therm_popcount #(
    parameter int CODE_W = 32,
    parameter int CNT_W  = $clog2(CODE_W + 1)
) (
    input  logic [CODE_W-1:0] code,
    output logic [CNT_W-1:0]  count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < CODE_W; i++) begin
            count = count + CNT_W'(code[i]);
        end
    end
endmodule

// File: rtl/tdc_therm_decoder.sv
// Turns each UP/DWN comparison window into one signed phase-error sample
// with saturation/timeout flags and a lock indicator for the loop filter.
module tdc_therm_decoder
    import tdc_pkg::*;
#(
    parameter int CODE_W     = TDC_CODE_W,
    parameter int ERR_W      = err_w_for(CODE_W),
    parameter int TIMEOUT    = 64,
    parameter int LOCK_TOL   = 2,
    parameter int LOCK_COUNT = 8
) (
    input  logic                clk,
    input  logic                reset,
    tdc_therm_decoder_if.slave  bus,
    output state_t              dbg_state
);
    localparam int CNT_W = $clog2(CODE_W + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);

    logic [CODE_W-1:0] up_q, up_d, dwn_q, dwn_d;
    logic [CNT_W-1:0]  up_cnt, dwn_cnt;
    logic [CNT_W-1:0]  up_peak_q, up_peak_d, dwn_peak_q, dwn_peak_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [ERR_W-1:0]  phase_err_q, phase_err_d;
    logic              err_valid_q, err_valid_d;
    logic              sat_q, sat_d, timeout_q, timeout_d, lock_q, lock_d;
    state_t            state_q, state_d;

    logic              any_code, emit, emit_timeout, emit_sat, in_tol;
    logic [CNT_W-1:0]  up_max, dwn_max, emit_up, emit_dwn;
    logic [ERR_W-1:0]  phase_new, phase_abs;

    therm_popcount #(.CODE_W(CODE_W), .CNT_W(CNT_W)) u_up_cnt  (.code(up_q),  .count(up_cnt));
    therm_popcount #(.CODE_W(CODE_W), .CNT_W(CNT_W)) u_dwn_cnt (.code(dwn_q), .count(dwn_cnt));

    always_comb begin
        up_d         = bus.up_error;
        dwn_d        = bus.dwn_error;
        state_d      = state_q;
        up_peak_d    = up_peak_q;
        dwn_peak_d   = dwn_peak_q;
        timer_d      = timer_q;
        lock_cnt_d   = lock_cnt_q;
        phase_err_d  = phase_err_q;
        err_valid_d  = 1'b0;
        sat_d        = sat_q;
        timeout_d    = timeout_q;
        lock_d       = lock_q;
        emit         = 1'b0;
        emit_timeout = 1'b0;
        emit_up      = up_peak_q;
        emit_dwn     = dwn_peak_q;

        any_code = (|up_q) || (|dwn_q);
        up_max   = (up_cnt  > up_peak_q)  ? up_cnt  : up_peak_q;
        dwn_max  = (dwn_cnt > dwn_peak_q) ? dwn_cnt : dwn_peak_q;

        case (state_q)
            IDLE: begin
                if (any_code) begin
                    state_d    = MEASURE;
                    up_peak_d  = up_cnt;
                    dwn_peak_d = dwn_cnt;
                    timer_d    = TMR_W'(1);
                end
            end
            MEASURE: begin
                // Window end is checked first so it wins over a coincident timeout.
                if (!any_code) begin
                    emit       = 1'b1;
                    state_d    = IDLE;
                    up_peak_d  = '0;
                    dwn_peak_d = '0;
                    timer_d    = '0;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    emit         = 1'b1;
                    emit_timeout = 1'b1;
                    emit_up      = up_max;
                    emit_dwn     = dwn_max;
                    state_d      = DRAIN;
                    up_peak_d    = '0;
                    dwn_peak_d   = '0;
                    timer_d      = '0;
                end else begin
                    up_peak_d  = up_max;
                    dwn_peak_d = dwn_max;
                    timer_d    = timer_q + TMR_W'(1);
                end
            end
            DRAIN: begin
                if (!any_code) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        phase_new = ERR_W'(emit_up) - ERR_W'(emit_dwn);
        phase_abs = phase_new[ERR_W-1] ? (~phase_new + ERR_W'(1)) : phase_new;
        emit_sat  = (emit_up == CNT_W'(CODE_W)) || (emit_dwn == CNT_W'(CODE_W));
        in_tol    = (phase_abs <= ERR_W'(LOCK_TOL)) && !emit_timeout && !emit_sat;

        if (emit) begin
            phase_err_d = phase_new;
            err_valid_d = 1'b1;
            sat_d       = emit_sat;
            timeout_d   = emit_timeout;
            if (!in_tol)                               lock_cnt_d = '0;
            else if (lock_cnt_q != LCK_W'(LOCK_COUNT)) lock_cnt_d = lock_cnt_q + LCK_W'(1);
            lock_d = (lock_cnt_d == LCK_W'(LOCK_COUNT));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_q        <= '0;
            dwn_q       <= '0;
            state_q     <= IDLE;
            up_peak_q   <= '0;
            dwn_peak_q  <= '0;
            timer_q     <= '0;
            lock_cnt_q  <= '0;
            phase_err_q <= '0;
            err_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            timeout_q   <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            up_q        <= up_d;
            dwn_q       <= dwn_d;
            state_q     <= state_d;
            up_peak_q   <= up_peak_d;
            dwn_peak_q  <= dwn_peak_d;
            timer_q     <= timer_d;
            lock_cnt_q  <= lock_cnt_d;
            phase_err_q <= phase_err_d;
            err_valid_q <= err_valid_d;
            sat_q       <= sat_d;
            timeout_q   <= timeout_d;
            lock_q      <= lock_d;
        end
    end

    assign bus.phase_err = phase_err_q;
    assign bus.err_valid = err_valid_q;
    assign bus.sat       = sat_q;
    assign bus.timeout   = timeout_q;
    assign bus.lock      = lock_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Directed bench for tdc_therm_decoder: window table plus hand-written
// timeout, coincidence, back-to-back and mid-window reset sequences.
module tb_tdc_therm_decoder;
    import tdc_pkg::*;

    localparam int CODE_W = 32;
    localparam int ERR_W  = 7;

    typedef struct {
        logic [CODE_W-1:0] up_a;
        logic [CODE_W-1:0] dwn_a;
        logic [CODE_W-1:0] up_b;
        logic [CODE_W-1:0] dwn_b;
        int                hold;
        int                exp_err;
        int                exp_sat;
        int                exp_lock;
    } vec_t;

    logic   clk;
    logic   reset;
    state_t dbg_state;
    int     n_checks;
    int     n_errors;
    int     strobe_cnt;
    int     exp_strobes;

    tdc_therm_decoder_if #(.CODE_W(CODE_W), .ERR_W(ERR_W)) bus ();

    tdc_therm_decoder #(
        .CODE_W(CODE_W), .ERR_W(ERR_W), .TIMEOUT(64), .LOCK_TOL(2), .LOCK_COUNT(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.err_valid === 1'b1) strobe_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CODE_W-1:0] up, input logic [CODE_W-1:0] dwn);
        bus.up_error  = up;
        bus.dwn_error = dwn;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Ticks until err_valid is seen; cycles = -1 when the budget runs out.
    task automatic wait_strobe(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.err_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic check_sample(input string tag, input int err, input int sat,
                                input int tmo, input int lck);
        check({tag, "_err"},     int'($signed(bus.phase_err)), err);
        check({tag, "_sat"},     int'(bus.sat), sat);
        check({tag, "_timeout"}, int'(bus.timeout), tmo);
        check({tag, "_lock"},    int'(bus.lock), lck);
    endtask

    task automatic apply_window(input vec_t v, input int idx);
        int    lat;
        string tag;
        tag = $sformatf("win%0d", idx);
        drive(v.up_a, v.dwn_a);
        tick();
        for (int i = 0; i < v.hold; i++) begin
            drive(v.up_b, v.dwn_b);
            tick();
        end
        drive('0, '0);
        wait_strobe(10, lat);
        check({tag, "_latency"}, lat, 2);
        check_sample(tag, v.exp_err, v.exp_sat, 0, v.exp_lock);
        exp_strobes++;
        tick();
        check({tag, "_one_cycle"}, int'(bus.err_valid), 0);
    endtask

    // ---------------- scoreboard / sequences ----------------
    vec_t tbl[12];

    initial begin
        logic [CODE_W-1:0] ramp[5];
        int                lat;
        int                seen;
        int                st_idx[4];
        int                st_err[4];
        int                st_tmo[4];
        int                st_sat[4];
        int                strobes_before;

        n_checks = 0; n_errors = 0; strobe_cnt = 0; exp_strobes = 0;

        //          up_a          dwn_a         up_b          dwn_b         hold err sat lock
        tbl[0]  = '{32'h1,        32'h1F,       32'h3,        32'h1FF,      2,  -7, 0, 0};
        tbl[1]  = '{32'h1,        32'h1F,       32'hB,        32'h1FF,      2,  -6, 0, 0};
        tbl[2]  = '{32'h1,        32'h0,        32'h1,        32'h0,        3,   1, 0, 0};
        tbl[3]  = '{32'h0,        32'h3,        32'h0,        32'h3,        3,  -2, 0, 0};
        tbl[4]  = '{32'h7,        32'h7,        32'h1,        32'h1,        3,   0, 0, 0};
        tbl[5]  = '{32'hF,        32'h3,        32'hF,        32'h3,        3,   2, 0, 0};
        tbl[6]  = '{32'h1,        32'h5,        32'h1,        32'h5,        3,  -1, 0, 0};
        tbl[7]  = '{32'h101,      32'h3,        32'h101,      32'h3,        3,   0, 0, 0};
        tbl[8]  = '{32'h7,        32'h3,        32'h7,        32'h3,        3,   1, 0, 0};
        tbl[9]  = '{32'h1,        32'h7,        32'h1,        32'h7,        3,  -2, 0, 1};
        tbl[10] = '{32'h3F,       32'h1,        32'h3F,       32'h1,        3,   5, 0, 0};
        tbl[11] = '{32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h0,        39, 32, 1, 0};

        ramp[0] = 32'h1; ramp[1] = 32'h3; ramp[2] = 32'h7; ramp[3] = 32'hF; ramp[4] = 32'h1F;

        // Reset state
        reset = 1'b1;
        drive('0, '0);
        repeat (3) tick();
        check("rst_err_valid", int'(bus.err_valid), 0);
        check_sample("rst", 0, 0, 0, 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        reset = 1'b0;
        repeat (2) tick();

        // Rising UP ramp, DWN idle: +5 two edges after the zero is driven
        for (int i = 0; i < 5; i++) begin
            drive(ramp[i], '0);
            tick();
        end
        drive('0, '0);
        wait_strobe(10, lat);
        check("ramp_latency", lat, 2);
        check_sample("ramp", 5, 0, 0, 0);
        exp_strobes++;
        tick();
        check("ramp_one_cycle", int'(bus.err_valid), 0);

        // Table: peak hold, bubbles, lock build-up and loss, saturation
        for (int k = 0; k < 12; k++) begin
            apply_window(tbl[k], k);
            tick();
        end
        check("table_strobes", strobe_cnt, exp_strobes);

        // Timeout: one IDLE cycle then 64 timer cycles, so the strobe follows drive 65.
        // The count at the deciding cycle (0xF) must enter the peak.
        seen = 0; st_idx[0] = -1; st_err[0] = 0; st_tmo[0] = 0; st_sat[0] = 0;
        for (int i = 0; i < 70; i++) begin
            drive((i == 64) ? 32'hF : 32'h3, 32'h1);
            tick();
            if (bus.err_valid === 1'b1) begin
                if (seen < 4) begin
                    st_idx[seen] = i;
                    st_err[seen] = int'($signed(bus.phase_err));
                    st_tmo[seen] = int'(bus.timeout);
                    st_sat[seen] = int'(bus.sat);
                end
                seen++;
            end
            if (i == 67) check("tmo_drain_state", int'(dbg_state), int'(DRAIN));
        end
        check("tmo_strobe_count", seen, 1);
        check("tmo_strobe_index", st_idx[0], 65);
        check("tmo_err", st_err[0], 3);
        check("tmo_timeout", st_tmo[0], 1);
        check("tmo_sat", st_sat[0], 0);
        check("tmo_lock", int'(bus.lock), 0);
        drive('0, '0);
        repeat (3) tick();
        check("tmo_idle_state", int'(dbg_state), int'(IDLE));
        exp_strobes++;
        check("tmo_total_strobes", strobe_cnt, exp_strobes);

        // Window end on the timer==TIMEOUT cycle, then a one-cycle window right after
        seen = 0;
        for (int j = 0; j < 4; j++) begin
            st_idx[j] = -1; st_err[j] = 0; st_tmo[j] = 0; st_sat[j] = 0;
        end
        for (int i = 0; i < 72; i++) begin
            if (i < 64)       drive(32'h7, '0);
            else if (i == 65) drive(32'h1, 32'h1F);
            else              drive('0, '0);
            tick();
            if (bus.err_valid === 1'b1) begin
                if (seen < 4) begin
                    st_idx[seen] = i;
                    st_err[seen] = int'($signed(bus.phase_err));
                    st_tmo[seen] = int'(bus.timeout);
                    st_sat[seen] = int'(bus.sat);
                end
                seen++;
            end
        end
        check("coin_strobe_count", seen, 2);
        check("coin_first_index", st_idx[0], 65);
        check("coin_first_err", st_err[0], 3);
        check("coin_first_timeout", st_tmo[0], 0);
        check("coin_second_index", st_idx[1], 67);
        check("coin_second_err", st_err[1], -4);
        check("coin_second_timeout", st_tmo[1], 0);
        check("coin_second_sat", st_sat[1], 0);
        exp_strobes += 2;

        // Asynchronous reset in the middle of a 12-one window
        for (int i = 0; i < 5; i++) begin
            drive(32'hFFF, '0);
            tick();
        end
        check("pre_rst_state", int'(dbg_state), int'(MEASURE));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_err_valid", int'(bus.err_valid), 0);
        check_sample("midrst", 0, 0, 0, 0);
        check("midrst_state", int'(dbg_state), int'(IDLE));
        drive('0, '0);
        repeat (2) tick();
        reset = 1'b0;
        strobes_before = strobe_cnt;
        repeat (6) tick();
        check("midrst_no_strobe", strobe_cnt - strobes_before, 0);
        check("final_strobes", strobes_before, exp_strobes);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case a sequence stalls; reported as a failed check.
    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected end of test");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/tdc_therm_decoder.md
Name: tdc_therm_decoder

Overview:
- Downstream consumer of the 32-bit UP/DWN thermometer codes produced by the sequential-PD TDC.
- Converts each comparison window into one signed phase-error sample with a valid strobe, for the ADPLL digital loop filter.
- Tracks the peak code per window. Emits at window end, when both codes return to zero.
- Also flags saturation and timeout, and maintains a lock indicator.

Parameters:
- CODE_W, 32, width of each thermometer input.
- ERR_W, 7, signed error width; must hold ±CODE_W, i.e. clog2(CODE_W)+2.
- TIMEOUT, 64, max clk cycles a window may stay open before forced emission.
- LOCK_TOL, 2, max |phase_err| counted as in-lock.
- LOCK_COUNT, 8, consecutive in-lock samples required to assert lock.

Ports:
- clk  in  1  system sampling clock; same clock as the TDC shift registers.
- reset  in  1  asynchronous, active-high reset.
- up_error  in  CODE_W  UP thermometer code from the TDC.
- dwn_error  in  CODE_W  DWN thermometer code from the TDC.
- phase_err  out  ERR_W  signed: up_peak minus dwn_peak; positive means reference leads.
- err_valid  out  1  one-cycle strobe; phase_err/sat/timeout are valid while high.
- sat  out  1  either peak reached CODE_W (all ones) in the emitted window.
- timeout  out  1  the emitted window was forced by TIMEOUT.
- lock  out  1  loop-lock indicator.

Behaviour:
- Reset (async, any time, including mid-window):
  - phase_err=0, err_valid=0, sat=0, timeout=0, lock=0.
  - Peaks, timer and lock counter cleared; input registers cleared; state=IDLE.
- Input stage: up_error/dwn_error registered once into up_q/dwn_q on every clk edge. The TDC's own async clears are absorbed here.
- Count: up_cnt/dwn_cnt = popcount of up_q/dwn_q, range 0..CODE_W, 6 bits for CODE_W=32. Popcount makes bubbles tolerated: 0b1011 counts 3.
- Peaks: while in MEASURE, up_peak <= max(up_peak, up_cnt); likewise dwn_peak.
- States:
  - IDLE: both up_q and dwn_q zero, waiting. Any nonzero in up_q or dwn_q -> MEASURE. On that edge, peaks load the current counts and timer=1.
  - MEASURE:
    - Update peaks; timer++.
    - Both up_q and dwn_q zero -> emit, clear peaks, go to IDLE.
    - Else timer==TIMEOUT -> emit with timeout=1 (peaks including this cycle's counts), go to DRAIN.
    - Window-end and timeout on the same edge: window-end wins, timeout=0.
  - DRAIN: no emission. Both inputs zero -> IDLE. Nonzero codes are ignored.
- Emit (registered, on the deciding edge):
  - phase_err = up_peak - dwn_peak, sign-extended to ERR_W. Range -CODE_W..+CODE_W, no overflow.
  - err_valid=1 for exactly one cycle.
  - sat = (up_peak==CODE_W) or (dwn_peak==CODE_W).
- Latency: err_valid rises on the edge after the edge at which up_q and dwn_q both become zero. Between emissions, outputs hold their last value and err_valid=0.
- Back-to-back windows: a nonzero code arriving the cycle after emission opens a new window normally from IDLE. Minimum spacing between strobes is 2 cycles.
- Lock, updated only on emission:
  - If |phase_err_new| <= LOCK_TOL and timeout=0 and sat=0: lock_cnt++, saturating at LOCK_COUNT. Otherwise lock_cnt=0 and lock deasserts.
  - lock=1 when lock_cnt reaches LOCK_COUNT, visible the same cycle as the qualifying err_valid.

Decomposition:
- Shared package tdc_pkg holds:
  - state enum {IDLE, MEASURE, DRAIN};
  - an ERR_W derivation function from CODE_W;
  - the CODE_W default constant, shared with the TDC.
- Sub-module therm_popcount: parameterised CODE_W combinational ones-counter, instantiated twice (UP and DWN).
- FSM, peak hold and lock logic stay in the top module.

Test Plan:
- After reset, up_error steps 1,3,7,15,31 (one per clk), then 0; dwn stays 0 -> single err_valid, phase_err=+5, sat=0, timeout=0, issued on the edge after the zero is registered.
- dwn_error ramps to 9 ones, up_error to 2 ones, then both go to 0 together -> phase_err=-7. Repeat with up_error=0b1011 as the peak -> up_peak=3.
- up_error held all ones for 40 cycles, then 0 -> phase_err=+32, sat=1, timeout=0. Hold nonzero 70 cycles instead -> err_valid at cycle 64 with timeout=1, no second strobe, DRAIN then IDLE.
- LOCK_TOL=2, LOCK_COUNT=8: eight windows with errors +1,-2,0,+2,-1,0,+1,-2 -> lock rises on the 8th strobe. Next window +5 -> lock=0 on that strobe.
- Assert reset mid-MEASURE with up_peak=12 -> all outputs 0 immediately. Codes then return to 0 -> no err_valid.
- Window-end coinciding with timer==TIMEOUT -> timeout=0 and a normal emission; a new window opening the cycle after the strobe is measured correctly.
